// File: rtl/spi_slave_bridge_pkg.sv
// Shared constants for the SPI slave bridge: FSM state codes, R/W command bit
// values and status-word bit offsets.
package spi_bridge_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_COMMIT = 3'd4;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    // Flag positions counted upward from the bit just above the fifo_count field
    localparam int STAT_EMPTY_OFS     = 0;
    localparam int STAT_FULL_OFS      = 1;
    localparam int STAT_UNDERFLOW_OFS = 2;
    localparam int STAT_OVERFLOW_OFS  = 3;

endpackage

// File: rtl/spi_slave_bridge_if.sv
// SPI pin bundle between the GPIO header (master side) and the bridge (slave side).
interface spi_slave_bridge_if;
    logic spi_sclk;
    logic spi_ssn;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (output spi_sclk, output spi_ssn, output spi_mosi,
                    input  spi_miso, input  spi_miso_oe);
    modport slave  (input  spi_sclk, input  spi_ssn, input  spi_mosi,
                    output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/spi_slave_bridge_fifo.sv
// Single-clock FIFO used as the bridge's push/pop mailbox; head word is visible
// on dout without a pop.
module spi_sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             din,
    input  logic                          pop,
    output logic [DATA_W-1:0]             dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally on overflow of their width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/spi_slave_bridge.sv
// SPI slave that decodes {address, R/W, pad} + data frames and routes them to a
// FIFO, a register file exported to the fabric, or a read-only status word.
module spi_slave_bridge
    import spi_bridge_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              CMD_W       = 16,
    parameter int              DATA_W      = 16,
    parameter int              FIFO_DEPTH  = 8,
    parameter int              NUM_REGS    = 4,
    parameter logic [ADDR_W-1:0] FIFO_ADDR   = 8'h80,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 8'h81,
    parameter int              SPI_MODE    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    spi_slave_bridge_if.slave            spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_q,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         frame_done
);
    localparam int   CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int   BCNT_W    = $clog2(((CMD_W > DATA_W) ? CMD_W : DATA_W) + 1);
    localparam int   REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic CPOL      = ((SPI_MODE / 2) % 2) == 1;
    localparam logic CPHA      = (SPI_MODE % 2) == 1;

    logic [1:0] sclk_s, ssn_s, mosi_s;
    logic       sclk_d, ssn_d;

    // Synchronizers idle at the bus rest levels so reset never fakes an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s <= {2{CPOL}};
            ssn_s  <= 2'b11;
            mosi_s <= 2'b00;
            sclk_d <= CPOL;
            ssn_d  <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[0], spi.spi_sclk};
            ssn_s  <= {ssn_s[0], spi.spi_ssn};
            mosi_s <= {mosi_s[0], spi.spi_mosi};
            sclk_d <= sclk_s[1];
            ssn_d  <= ssn_s[1];
        end
    end

    logic sclk_n, sclk_n_d, sample_edge, launch_edge, ssn_fall, ssn_rise;
    assign sclk_n      = sclk_s[1] ^ CPOL;
    assign sclk_n_d    = sclk_d ^ CPOL;
    assign sample_edge = CPHA ? (!sclk_n && sclk_n_d) : (sclk_n && !sclk_n_d);
    assign launch_edge = CPHA ? (sclk_n && !sclk_n_d) : (!sclk_n && sclk_n_d);
    assign ssn_fall    = ssn_d && !ssn_s[1];
    assign ssn_rise    = !ssn_d && ssn_s[1];

    state_t              state;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [CMD_W-1:0]    cmd_sr;
    logic [DATA_W-1:0]   data_sr;
    logic [DATA_W-1:0]   miso_sr;
    logic [ADDR_W-1:0]   addr_q;
    logic                rw_q;
    logic                first_launch;
    logic                overflow, underflow;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_dout;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_rw;
    logic                cmd_is_reg, addr_q_is_reg;
    logic [DATA_W-1:0]   status_word, rd_word;

    assign cmd_addr      = cmd_sr[CMD_W-1 -: ADDR_W];
    assign cmd_rw        = cmd_sr[CMD_W-1-ADDR_W];
    assign cmd_is_reg    = cmd_addr < ADDR_W'(NUM_REGS);
    assign addr_q_is_reg = addr_q < ADDR_W'(NUM_REGS);

    assign fifo_pop  = (state == ST_DECODE) && (cmd_rw == CMD_READ) &&
                       (cmd_addr == FIFO_ADDR) && !fifo_empty;
    assign fifo_push = (state == ST_COMMIT) && (rw_q == CMD_WRITE) &&
                       (addr_q == FIFO_ADDR) && !fifo_full;

    always_comb begin
        status_word = '0;
        status_word[CNT_W-1:0]                    = fifo_count;
        status_word[CNT_W + STAT_EMPTY_OFS]       = fifo_empty;
        status_word[CNT_W + STAT_FULL_OFS]        = fifo_full;
        status_word[CNT_W + STAT_UNDERFLOW_OFS]   = underflow;
        status_word[CNT_W + STAT_OVERFLOW_OFS]    = overflow;
        rd_word = '0;
        if (cmd_addr == FIFO_ADDR)        rd_word = fifo_empty ? '0 : fifo_dout;
        else if (cmd_addr == STATUS_ADDR) rd_word = status_word;
        else if (cmd_is_reg)              rd_word = regs[cmd_addr[REG_IDX_W-1:0]];
    end

    // Frame sequencer; an ssn release before COMMIT drops the frame without side effects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            data_sr      <= '0;
            miso_sr      <= '0;
            addr_q       <= '0;
            rw_q         <= CMD_WRITE;
            first_launch <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            frame_done   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ssn_fall) begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                        cmd_sr  <= '0;
                    end
                end
                ST_CMD: begin
                    if (ssn_rise) begin
                        state <= ST_IDLE;
                    end else if (sample_edge) begin
                        cmd_sr  <= {cmd_sr[CMD_W-2:0], mosi_s[1]};
                        bit_cnt <= bit_cnt + BCNT_W'(1);
                        if (bit_cnt == BCNT_W'(CMD_W-1)) state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    addr_q       <= cmd_addr;
                    rw_q         <= cmd_rw;
                    bit_cnt      <= '0;
                    data_sr      <= '0;
                    first_launch <= 1'b1;
                    miso_sr      <= (cmd_rw == CMD_READ) ? rd_word : '0;
                    if (cmd_rw == CMD_READ && cmd_addr == FIFO_ADDR && fifo_empty)
                        underflow <= 1'b1;
                    if (cmd_rw == CMD_READ && cmd_addr == STATUS_ADDR) begin
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                    state <= ssn_rise ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (ssn_rise) begin
                        state <= ST_IDLE;
                    end else begin
                        if (sample_edge) begin
                            data_sr <= {data_sr[DATA_W-2:0], mosi_s[1]};
                            bit_cnt <= bit_cnt + BCNT_W'(1);
                            if (!CPHA) miso_sr <= {miso_sr[DATA_W-2:0], 1'b0};
                            if (bit_cnt == BCNT_W'(DATA_W-1)) state <= ST_COMMIT;
                        end
                        // In CPHA=1 the first launch edge presents the word loaded in DECODE
                        if (launch_edge && CPHA) begin
                            if (first_launch) first_launch <= 1'b0;
                            else              miso_sr <= {miso_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                ST_COMMIT: begin
                    if (rw_q == CMD_WRITE) begin
                        if (addr_q == FIFO_ADDR && fifo_full) overflow <= 1'b1;
                        if (addr_q_is_reg) regs[addr_q[REG_IDX_W-1:0]] <= data_sr;
                    end
                    frame_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) regs_q[k*DATA_W +: DATA_W] = regs[k];
    end

    assign spi.spi_miso    = (state == ST_DATA) ? miso_sr[DATA_W-1] : 1'b0;
    assign spi.spi_miso_oe = !ssn_s[1];

    spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (data_sr),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: a mode-0 instance and a mode-3 instance
// driven by a bit-banged SPI master, read data checked through a scoreboard queue.
module tb_spi_slave_bridge;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    spi_slave_bridge_if bus0 ();
    spi_slave_bridge_if bus3 ();

    logic [63:0] regs_q0, regs_q3;
    logic [3:0]  cnt0, cnt3;
    logic        fd0, fd3;

    spi_slave_bridge #(.SPI_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .spi(bus0),
        .regs_q(regs_q0), .fifo_count(cnt0), .frame_done(fd0));

    spi_slave_bridge #(.SPI_MODE(3)) dut3 (
        .clk(clk), .reset(reset), .spi(bus3),
        .regs_q(regs_q3), .fifo_count(cnt3), .frame_done(fd3));

    int fd_cnt0 = 0;
    int fd_cnt3 = 0;
    always @(posedge clk) begin
        if (fd0) fd_cnt0 <= fd_cnt0 + 1;
        if (fd3) fd_cnt3 <= fd_cnt3 + 1;
    end

    int checks = 0;
    int passes = 0;
    logic [15:0] exp_q [$];

    // Reference model of the mode-0 instance
    logic [15:0] m_regs [4];
    logic [15:0] m_fifo [$];
    logic        m_ovf, m_unf;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_fifo.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [15:0] d);
        if (a == 8'h80) begin
            if (m_fifo.size() == 8) m_ovf = 1'b1;
            else                    m_fifo.push_back(d);
        end else if (a < 8'd4) begin
            m_regs[a[1:0]] = d;
        end
    endtask

    task automatic model_read(input logic [7:0] a, output logic [15:0] v);
        logic [3:0] c;
        v = '0;
        c = 4'(m_fifo.size());
        if (a == 8'h80) begin
            if (m_fifo.size() == 0) m_unf = 1'b1;
            else                    v = m_fifo.pop_front();
        end else if (a == 8'h81) begin
            v = {8'h00, m_ovf, m_unf, (c == 4'd8), (c == 4'd0), c};
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (a < 8'd4) begin
            v = m_regs[a[1:0]];
        end
    endtask

    task automatic drive(input bit sel, input logic sclk, input logic ssn, input logic mosi);
        if (sel) begin
            bus3.spi_sclk = sclk; bus3.spi_ssn = ssn; bus3.spi_mosi = mosi;
        end else begin
            bus0.spi_sclk = sclk; bus0.spi_ssn = ssn; bus0.spi_mosi = mosi;
        end
    endtask

    // One frame: 16 command bits then nbits data bits; sel=0 mode 0 @10 MHz, sel=1 mode 3
    task automatic apply_stimulus(input bit sel, input logic [7:0] addr, input logic rw,
                                  input logic [15:0] wdata, input int nbits,
                                  input bit release_ssn, output logic [15:0] rdata);
        logic [31:0] frame;
        logic        cpol, b, miso;
        int          half;
        frame = {addr, rw, 7'b0, wdata};
        cpol  = sel;
        half  = sel ? 120 : 50;
        rdata = '0;
        drive(sel, cpol, 1'b0, 1'b0);
        #100;
        for (int i = 0; i < 16 + nbits; i++) begin
            b = frame[31-i];
            if (!sel) begin
                drive(sel, cpol, 1'b0, b);
                #(half - 5);
                miso = bus0.spi_miso;
                #5 drive(sel, ~cpol, 1'b0, b);
                #(half) drive(sel, cpol, 1'b0, b);
            end else begin
                drive(sel, ~cpol, 1'b0, b);
                #(half - 5);
                miso = bus3.spi_miso;
                #5 drive(sel, cpol, 1'b0, b);
                #(half);
            end
            if (i >= 16) rdata = {rdata[14:0], miso};
        end
        #(half);
        if (release_ssn) begin
            drive(sel, cpol, 1'b1, 1'b0);
            #300;
        end
        @(negedge clk);
    endtask

    task automatic do_write(input bit sel, input logic [7:0] a, input logic [15:0] d);
        logic [15:0] rd;
        apply_stimulus(sel, a, 1'b0, d, 16, 1'b1, rd);
        if (!sel) model_write(a, d);
    endtask

    task automatic do_read0(input logic [7:0] a, input string tag);
        logic [15:0] v, rd;
        model_read(a, v);
        exp_q.push_back(v);
        apply_stimulus(1'b0, a, 1'b1, 16'h0000, 16, 1'b1, rd);
        check_output(tag, {48'h0, rd}, {48'h0, exp_q.pop_front()});
    endtask

    task automatic do_read3(input logic [7:0] a, input logic [15:0] v, input string tag);
        logic [15:0] rd;
        exp_q.push_back(v);
        apply_stimulus(1'b1, a, 1'b1, 16'h0000, 16, 1'b1, rd);
        check_output(tag, {48'h0, rd}, {48'h0, exp_q.pop_front()});
    endtask

    initial begin
        int          base;
        logic [15:0] rd;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check_output("rst_regs0", regs_q0, 64'h0);
        check_output("rst_count0", {60'h0, cnt0}, 64'h0);
        check_output("rst_miso0", {63'h0, bus0.spi_miso}, 64'h0);
        check_output("rst_oe0", {63'h0, bus0.spi_miso_oe}, 64'h0);
        check_output("rst_done0", {63'h0, fd0}, 64'h0);
        check_output("rst_regs3", regs_q3, 64'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] mode 0 fifo/register traffic");
        base = fd_cnt0;
        do_write(1'b0, 8'h80, 16'h00f1);
        do_write(1'b0, 8'h80, 16'h00f2);
        do_write(1'b0, 8'h80, 16'h00f3);
        do_write(1'b0, 8'h02, 16'h2000);
        check_output("count_after_push", {60'h0, cnt0}, 64'd3);
        do_read0(8'h80, "rd_fifo_f1");
        do_read0(8'h02, "rd_reg2");
        do_read0(8'h80, "rd_fifo_f2");
        do_read0(8'h80, "rd_fifo_f3");
        check_output("regs_q2", {48'h0, regs_q0[47:32]}, 64'h2000);
        check_output("frame_done_cnt", 64'(fd_cnt0 - base), 64'd8);

        $display("[TB] overflow");
        for (int i = 0; i < 9; i++) do_write(1'b0, 8'h80, 16'h0100 + 16'(i));
        check_output("count_full", {60'h0, cnt0}, 64'd8);
        do_read0(8'h81, "status_ovf");
        check_output("status_ovf_const", {48'h0, 16'h00a8}, 64'h00a8 & {48'h0, 16'hffff});
        do_read0(8'h81, "status_ovf_cleared");
        for (int i = 0; i < 8; i++) do_read0(8'h80, "rd_drain");

        $display("[TB] underflow");
        do_read0(8'h80, "rd_empty");
        do_read0(8'h81, "status_unf");
        check_output("count_empty", {60'h0, cnt0}, 64'd0);

        $display("[TB] abort");
        base = fd_cnt0;
        apply_stimulus(1'b0, 8'h01, 1'b0, 16'habcd, 8, 1'b1, rd);
        check_output("abort_reg1", {48'h0, regs_q0[31:16]}, 64'h0);
        check_output("abort_no_done", 64'(fd_cnt0 - base), 64'd0);
        do_write(1'b0, 8'h01, 16'habcd);
        check_output("after_abort_reg1", {48'h0, regs_q0[31:16]}, 64'habcd);
        check_output("after_abort_done", 64'(fd_cnt0 - base), 64'd1);
        do_read0(8'h01, "rd_reg1");

        $display("[TB] mode 3");
        do_write(1'b1, 8'h03, 16'h1234);
        do_read3(8'h03, 16'h1234, "m3_rd_reg3");
        do_read3(8'h40, 16'h0000, "m3_rd_unmapped");
        check_output("m3_regs_q3", {48'h0, regs_q3[63:48]}, 64'h1234);
        check_output("m3_done_cnt", 64'(fd_cnt3), 64'd3);

        $display("[TB] reset during data phase");
        apply_stimulus(1'b0, 8'h02, 1'b0, 16'h5555, 8, 1'b0, rd);
        check_output("oe_mid_frame", {63'h0, bus0.spi_miso_oe}, 64'h1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("midrst_regs0", regs_q0, 64'h0);
        check_output("midrst_count0", {60'h0, cnt0}, 64'h0);
        check_output("midrst_miso0", {63'h0, bus0.spi_miso}, 64'h0);
        check_output("midrst_oe0", {63'h0, bus0.spi_miso_oe}, 64'h0);
        check_output("midrst_done0", {63'h0, fd0}, 64'h0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        #400;
        @(negedge clk);
        check_output("post_rst_regs0", regs_q0, 64'h0);
        do_write(1'b0, 8'h00, 16'hbeef);
        do_read0(8'h00, "post_rst_rd_reg0");
        check_output("post_rst_regs_q0", {48'h0, regs_q0[15:0]}, 64'hbeef);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
